// File: rtl/vga_timing_receiver.sv
// Purpose : recover line/frame timing from an incoming VGA hsync/vsync/RGB stream, lock, and tag active pixels.
// Latency : 4 clocks from input sample capture to pix_* output (3 sync/edge stages + counters + output register).
// Backpressure: none; free-running stream at the pixel clock, every sample is consumed.
//
// Ports:
//   clk, rst              pixel clock, synchronous active-high reset
//   hsync_in, vsync_in    active-low syncs (asynchronous phase), rgb_in {R,G,B} 4 bits each
//   pix_valid/x/y/rgb     active-area sample and its recovered coordinate
//   locked                timing lock status
//   h_total, v_total      last measured line length (clocks) and frame length (lines)
module vga_timing_receiver #(
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int H_ACTIVE    = 640,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int V_ACTIVE    = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [11:0] rgb_in,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [11:0] pix_rgb,
    output logic        locked,
    output logic [10:0] h_total,
    output logic [9:0]  v_total
);

    localparam logic [10:0] H_MAX = 11'h7FF;
    localparam logic [9:0]  V_MAX = 10'h3FF;
    localparam logic [10:0] HOFF  = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] HEND  = 11'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [9:0]  VOFF  = 10'(V_SYNC + V_BACK);
    localparam logic [9:0]  VEND  = 10'(V_SYNC + V_BACK + V_ACTIVE);
    localparam int          MW    = $clog2(LOCK_FRAMES + 1);
    localparam logic [MW-1:0] LOCK_N = MW'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

    // synchronizer / edge pipeline
    logic        hs_s1_q, hs_s2_q, hs_s3_q;
    logic        vs_s1_q, vs_s2_q, vs_s3_q;
    logic [11:0] rgb_s1_q, rgb_s2_q, rgb_s3_q, rgb_c_q;
    logic        hfall_q, vfall_q;

    // counters and lock state
    logic [10:0] h_q, h_ref_q;
    logic [9:0]  v_q, v_ref_q;
    logic        mism_q;
    logic [MW-1:0] match_q;
    state_t      state_q;

    logic [10:0] h_inc, h_d, h_tot_d;
    logic [9:0]  v_inc, v_d, v_tot_d;
    logic [MW-1:0] match_inc;
    logic        timeout, h_mis, v_match, active;

    // hfall_q/vfall_q/rgb_s3_q all describe the same sample: the one that was in stage 2
    // when the falling edge was seen against stage 3.
    always_ff @(posedge clk) begin
        if (rst) begin
            hs_s1_q  <= 1'b1; hs_s2_q <= 1'b1; hs_s3_q <= 1'b1;
            vs_s1_q  <= 1'b1; vs_s2_q <= 1'b1; vs_s3_q <= 1'b1;
            rgb_s1_q <= '0;   rgb_s2_q <= '0;  rgb_s3_q <= '0;
            hfall_q  <= 1'b0; vfall_q <= 1'b0;
        end else begin
            hs_s1_q  <= hsync_in; hs_s2_q  <= hs_s1_q;
            vs_s1_q  <= vsync_in; vs_s2_q  <= vs_s1_q;
            rgb_s1_q <= rgb_in;   rgb_s2_q <= rgb_s1_q;
            hs_s3_q  <= hs_s2_q;
            vs_s3_q  <= vs_s2_q;
            rgb_s3_q <= rgb_s2_q;
            hfall_q  <= hs_s3_q & ~hs_s2_q;
            vfall_q  <= vs_s3_q & ~vs_s2_q;
        end
    end

    always_comb begin
        h_inc     = (h_q == H_MAX) ? H_MAX : h_q + 11'd1;
        v_inc     = (v_q == V_MAX) ? V_MAX : v_q + 10'd1;
        h_d       = hfall_q ? 11'd0 : h_inc;
        // vsync wins over a coincident hsync fall
        v_d       = vfall_q ? 10'd0 : (hfall_q ? v_inc : v_q);
        h_tot_d   = hfall_q ? h_inc : h_total;
        // a coincident hsync fall closes the last line of the frame, so count it
        v_tot_d   = vfall_q ? (hfall_q ? v_inc : v_q) : v_total;
        timeout   = (h_d == H_MAX) || (v_d == V_MAX);
        h_mis     = hfall_q && (h_tot_d != h_ref_q);
        v_match   = (v_tot_d == v_ref_q);
        match_inc = match_q + 1'b1;
        // bounds checked before any subtraction, so ax/ay never wrap
        active    = (h_q >= HOFF) && (h_q < HEND) && (v_q >= VOFF) && (v_q < VEND);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_q     <= '0;
            v_q     <= '0;
            h_total <= '0;
            v_total <= '0;
            rgb_c_q <= '0;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            h_total <= h_tot_d;
            v_total <= v_tot_d;
            rgb_c_q <= rgb_s3_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEARCH;
            h_ref_q <= '0;
            v_ref_q <= '0;
            match_q <= '0;
            mism_q  <= 1'b0;
        end else if (timeout) begin
            state_q <= SEARCH;
            match_q <= '0;
            mism_q  <= 1'b0;
        end else begin
            case (state_q)
                SEARCH: begin
                    if (vfall_q) begin
                        h_ref_q <= h_tot_d;
                        v_ref_q <= v_tot_d;
                        match_q <= '0;
                        mism_q  <= 1'b0;
                        state_q <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (vfall_q) begin
                        if (!mism_q && !h_mis && v_match) begin
                            match_q <= match_inc;
                            if (match_inc == LOCK_N) state_q <= LOCKED;
                        end else begin
                            h_ref_q <= h_tot_d;
                            v_ref_q <= v_tot_d;
                            match_q <= '0;
                        end
                        mism_q <= 1'b0;
                    end else if (h_mis) begin
                        mism_q <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (h_mis || (vfall_q && !v_match)) state_q <= SEARCH;
                end
                default: state_q <= SEARCH;
            endcase
        end
    end

    // Output stage sees the state already updated for this sample, so a mismatching
    // edge drops locked/pix_valid together on the next output cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_valid <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_rgb   <= '0;
            locked    <= 1'b0;
        end else begin
            locked    <= (state_q == LOCKED);
            pix_valid <= (state_q == LOCKED) && active;
            if ((state_q == LOCKED) && active) begin
                pix_x   <= 10'(h_q - HOFF);
                pix_y   <= v_q - VOFF;
                pix_rgb <= rgb_c_q;
            end else begin
                pix_rgb <= '0;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_receiver.sv
// Purpose : directed, table-driven checks of vga_timing_receiver on a scaled-down raster.
// Latency : expects pix_* 4 clocks after the sample is captured.
// Backpressure: none; the bench drives one sample per clock.
module tb_vga_timing_receiver;

    localparam int HS = 4, HB = 3, HA = 8, HF = 5;
    localparam int HT = HS + HB + HA + HF;          // 20 clocks per line
    localparam int VS = 2, VB = 2, VA = 4, VF = 2;
    localparam int VT = VS + VB + VA + VF;          // 10 lines per frame

    logic        clk = 1'b0;
    logic        rst;
    logic        hsync_in, vsync_in;
    logic [11:0] rgb_in;
    logic        pix_valid, locked;
    logic [9:0]  pix_x, pix_y, v_total;
    logic [11:0] pix_rgb;
    logic [10:0] h_total;

    vga_timing_receiver #(
        .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA),
        .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .LOCK_FRAMES(2)
    ) dut (
        .clk(clk), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in), .rgb_in(rgb_in),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
        .locked(locked), .h_total(h_total), .v_total(v_total)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          ln;
        int          idx;
        logic [11:0] rgb;
        logic        vld;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [11:0] orgb;
    } probe_t;

    typedef struct {
        int due;
        int k;
    } pend_t;

    probe_t tbl [8];
    pend_t  pq [$];
    int     smp = 0;
    int     checks = 0;
    int     errors = 0;
    int     nv;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_pix_valid"}, pix_valid, 0);
        chk({tag, "_pix_x"}, pix_x, 0);
        chk({tag, "_pix_y"}, pix_y, 0);
        chk({tag, "_pix_rgb"}, pix_rgb, 0);
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_h_total"}, h_total, 0);
        chk({tag, "_v_total"}, v_total, 0);
    endtask

    // One frame of the raster. vs_off shifts the vsync fall within line 0,
    // short_line is one clock short, rst_line pulses reset mid active line,
    // chk_line checks locked at the 4th/5th observation after that line's first sample.
    task automatic drive_frame(input int short_line, input int vs_off, input int chk_line,
                               input int chk_b, input int chk_a, input int rst_line,
                               input bit use_tbl, output int nvalid);
        nvalid = 0;
        for (int ln = 0; ln < VT; ln++) begin
            int len;
            len = (ln == short_line) ? HT - 1 : HT;
            for (int idx = 0; idx < len; idx++) begin
                @(negedge clk);
                if (rst) begin
                    check_zero("midreset");
                    rst = 1'b0;
                end
                if (pix_valid) nvalid++;
                if (ln == chk_line && idx == 4 && chk_b >= 0) chk("lock_before_edge", locked, chk_b);
                if (ln == chk_line && idx == 5 && chk_a >= 0) chk("lock_after_edge", locked, chk_a);
                if (ln == chk_line && idx == 15 && chk_a == 0) chk("valid_after_loss", pix_valid, 0);
                while (pq.size() > 0 && pq[0].due == smp) begin
                    pend_t p;
                    p = pq.pop_front();
                    chk($sformatf("probe%0d_vld_x_y_rgb", p.k), {pix_valid, pix_x, pix_y, pix_rgb},
                        {tbl[p.k].vld, tbl[p.k].x, tbl[p.k].y, tbl[p.k].orgb});
                end
                hsync_in = (idx >= HS);
                vsync_in = !((ln > 0 || idx >= vs_off) && (ln < VS || (ln == VS && idx < vs_off)));
                rgb_in   = 12'h555;
                if (use_tbl) begin
                    for (int k = 0; k < 8; k++) begin
                        if (tbl[k].ln == ln && tbl[k].idx == idx) begin
                            rgb_in = tbl[k].rgb;
                            pq.push_back('{due: smp + 5, k: k});
                        end
                    end
                end
                if (ln == rst_line && idx == 10) rst = 1'b1;
                smp++;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // probe table: position, injected colour, expected {valid, x, y, rgb} 4 clocks later
        tbl[0] = '{0,  0, 12'h111, 1'b0, 10'd7, 10'd3, 12'h000};
        tbl[1] = '{3, 10, 12'h222, 1'b0, 10'd7, 10'd3, 12'h000};
        tbl[2] = '{4,  6, 12'h333, 1'b0, 10'd7, 10'd3, 12'h000};
        tbl[3] = '{4,  7, 12'hF00, 1'b1, 10'd0, 10'd0, 12'hF00};
        tbl[4] = '{4, 15, 12'h444, 1'b0, 10'd7, 10'd0, 12'h000};
        tbl[5] = '{5, 10, 12'h0A5, 1'b1, 10'd3, 10'd1, 12'h0A5};
        tbl[6] = '{7, 14, 12'h00F, 1'b1, 10'd7, 10'd3, 12'h00F};
        tbl[7] = '{8, 10, 12'h666, 1'b0, 10'd7, 10'd3, 12'h000};

        rst = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1; rgb_in = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // acquisition from reset: not locked before the 3rd vsync fall, locked by the 4th
        drive_frame(-1, 0, -1, -1, -1, -1, 1'b0, nv);
        drive_frame(-1, 0, -1, -1, -1, -1, 1'b0, nv);
        drive_frame(-1, 0,  0,  0, -1, -1, 1'b0, nv);
        drive_frame(-1, 0,  0, -1,  1, -1, 1'b0, nv);

        // fully locked frame: measurements and pixel count
        drive_frame(-1, 0, -1, -1, -1, -1, 1'b0, nv);
        chk("h_total", h_total, HT);
        chk("v_total_coincident", v_total, VT);
        chk("valid_count", nv, HA * VA);
        chk("locked_steady", locked, 1);

        // marker / boundary pixels
        drive_frame(-1, 0, -1, -1, -1, -1, 1'b1, nv);
        chk("probe_queue_drained", pq.size(), 0);

        // short line 6: lock lost at line 7's hsync fall, relock on the 3rd vsync fall
        drive_frame(6, 0, 7, 1, 0, -1, 1'b0, nv);
        chk("h_total_short", h_total, HT);
        drive_frame(-1, 0, -1, -1, -1, -1, 1'b0, nv);
        drive_frame(-1, 0, -1, -1, -1, -1, 1'b0, nv);
        chk("not_locked_2nd_fall", locked, 0);
        drive_frame(-1, 0,  0,  0,  1, -1, 1'b0, nv);

        // vsync falling mid-line (not coincident with hsync) measures the same frame length
        drive_frame(-1, 10, -1, -1, -1, -1, 1'b0, nv);
        chk("v_total_offset", v_total, VT);
        chk("locked_offset", locked, 1);
        drive_frame(-1, 10, -1, -1, -1, -1, 1'b0, nv);
        chk("valid_count_offset", nv, HA * VA);

        // reset pulse mid active line while locked, then reacquire
        drive_frame(-1, 0, -1, -1, -1, 5, 1'b0, nv);
        drive_frame(-1, 0, -1, -1, -1, -1, 1'b0, nv);
        drive_frame(-1, 0, -1, -1, -1, -1, 1'b0, nv);
        drive_frame(-1, 0,  0,  0, -1, -1, 1'b0, nv);
        drive_frame(-1, 0,  0, -1,  1, -1, 1'b0, nv);

        // hsync stuck high while locked: h counter saturation drops lock
        for (int k = 1; k <= 2100; k++) begin
            @(negedge clk);
            if (k == 100) chk("hold_still_locked", locked, 1);
            hsync_in = 1'b1;
            vsync_in = 1'b1;
            rgb_in   = 12'h555;
        end
        @(negedge clk);
        chk("hold_lock_lost", locked, 0);
        chk("hold_h_total", h_total, HT);
        chk("hold_no_valid", pix_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
